// File: rtl/cache_arbiter.sv
// Two-client arbiter that shares one physical-memory port between an
// instruction cache (read-only) and a data cache (read / write-back).
// One transaction is in flight at a time; simultaneous requests alternate.
module cache_arbiter #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  I_pmem_read,
    input  logic [ADDR_WIDTH-1:0] I_pmem_address,
    output logic                  I_pmem_resp,
    output logic [LINE_WIDTH-1:0] I_pmem_rdata,

    input  logic                  D_pmem_read,
    input  logic                  D_pmem_write,
    input  logic [ADDR_WIDTH-1:0] D_pmem_address,
    input  logic [LINE_WIDTH-1:0] D_pmem_wdata,
    output logic                  D_pmem_resp,
    output logic [LINE_WIDTH-1:0] D_pmem_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t                state;
    state_t                next_state;
    grant_t                last_grant;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] line_buf;
    logic                  write_q;

    logic                  i_req;
    logic                  d_req;
    logic                  grant_i;
    logic                  grant_d;
    logic                  serving;

    // Request decode and tie-break: on a tie the side not granted last wins.
    always_comb begin
        i_req   = I_pmem_read;
        d_req   = D_pmem_read | D_pmem_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            grant_i = i_req && (!d_req || (last_grant == GRANT_D));
            grant_d = d_req && (!i_req || (last_grant == GRANT_I));
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d)      next_state = SERVE_D;
                else if (grant_i) next_state = SERVE_I;
            end
            SERVE_I: if (pmem_resp) next_state = RESP_I;
            SERVE_D: if (pmem_resp) next_state = RESP_D;
            RESP_I:  next_state = IDLE;
            RESP_D:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Latch the granted request and capture the returned line on completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            line_buf   <= '0;
            last_grant <= GRANT_I;
        end else begin
            if (grant_d) begin
                addr_q  <= D_pmem_address;
                write_q <= D_pmem_write;
                if (D_pmem_write) wdata_q <= D_pmem_wdata;
            end else if (grant_i) begin
                addr_q  <= I_pmem_address;
                write_q <= 1'b0;
            end
            if (serving && pmem_resp) begin
                line_buf   <= pmem_rdata;
                last_grant <= (state == SERVE_I) ? GRANT_I : GRANT_D;
            end
        end
    end

    // Outputs decode from state and the latched request only.
    always_comb begin
        serving      = (state == SERVE_I) || (state == SERVE_D);
        pmem_read    = serving && !write_q;
        pmem_write   = serving && write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        I_pmem_resp  = (state == RESP_I);
        D_pmem_resp  = (state == RESP_D);
        I_pmem_rdata = line_buf;
        D_pmem_rdata = line_buf;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;

    localparam int LW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          I_pmem_read;
    logic [AW-1:0] I_pmem_address;
    logic          I_pmem_resp;
    logic [LW-1:0] I_pmem_rdata;
    logic          D_pmem_read;
    logic          D_pmem_write;
    logic [AW-1:0] D_pmem_address;
    logic [LW-1:0] D_pmem_wdata;
    logic          D_pmem_resp;
    logic [LW-1:0] D_pmem_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    int total = 0;
    int bad   = 0;

    localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] PAT_WD = {2{64'h0123456789ABCDEF}};
    localparam logic [LW-1:0] PAT_5A = {16{8'h5A}};

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .I_pmem_read(I_pmem_read), .I_pmem_address(I_pmem_address),
        .I_pmem_resp(I_pmem_resp), .I_pmem_rdata(I_pmem_rdata),
        .D_pmem_read(D_pmem_read), .D_pmem_write(D_pmem_write),
        .D_pmem_address(D_pmem_address), .D_pmem_wdata(D_pmem_wdata),
        .D_pmem_resp(D_pmem_resp), .D_pmem_rdata(D_pmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        I_pmem_read    = 1'b0;
        I_pmem_address = '0;
        D_pmem_read    = 1'b0;
        D_pmem_write   = 1'b0;
        D_pmem_address = '0;
        D_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({pmem_read, pmem_write, I_pmem_resp, D_pmem_resp} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000", {pmem_read, pmem_write, I_pmem_resp, D_pmem_resp});
        end
        total++;
        if (pmem_address !== '0 || pmem_wdata !== '0 || I_pmem_rdata !== '0 || D_pmem_rdata !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp=0", pmem_address, pmem_wdata, I_pmem_rdata);
        end
    endtask

    task automatic test_i_read();
        int rd_cycles;
        do_reset();
        I_pmem_read    = 1'b1;
        I_pmem_address = 16'h1230;
        total++;
        if (pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL i_read_early got=%b exp=0", pmem_read);
        end
        tick();
        I_pmem_read = 1'b0;
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h1230 || pmem_write !== 1'b0) begin
            bad++;
            $display("FAIL i_read_issue got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=1230", pmem_read, pmem_write, pmem_address);
        end
        rd_cycles = 1;
        tick();
        if (pmem_read === 1'b1) rd_cycles++;
        tick();
        if (pmem_read === 1'b1) rd_cycles++;
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_A5;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (pmem_read === 1'b1) rd_cycles++;
        total++;
        if (rd_cycles !== 3) begin
            bad++;
            $display("FAIL i_read_len got=%0d exp=3", rd_cycles);
        end
        total++;
        if (I_pmem_resp !== 1'b1 || I_pmem_rdata !== PAT_A5 || D_pmem_resp !== 1'b0) begin
            bad++;
            $display("FAIL i_read_resp got resp=%b dresp=%b rdata=%h exp resp=1 dresp=0 rdata=%h", I_pmem_resp, D_pmem_resp, I_pmem_rdata, PAT_A5);
        end
        tick();
        total++;
        if (I_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin
            bad++;
            $display("FAIL i_read_pulse got resp=%b rd=%b exp 0 0", I_pmem_resp, pmem_read);
        end
    endtask

    task automatic test_d_write();
        do_reset();
        D_pmem_write   = 1'b1;
        D_pmem_address = 16'h4000;
        D_pmem_wdata   = PAT_WD;
        tick();
        D_pmem_write = 1'b0;
        D_pmem_wdata = PAT_5A;
        total++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000 || pmem_wdata !== PAT_WD) begin
            bad++;
            $display("FAIL d_write_issue got wr=%b rd=%b addr=%h wdata=%h", pmem_write, pmem_read, pmem_address, pmem_wdata);
        end
        tick();
        total++;
        if (pmem_write !== 1'b1 || pmem_wdata !== PAT_WD) begin
            bad++;
            $display("FAIL d_write_hold got wr=%b wdata=%h exp wr=1 wdata=%h", pmem_write, pmem_wdata, PAT_WD);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        total++;
        if (D_pmem_resp !== 1'b1 || I_pmem_resp !== 1'b0 || pmem_write !== 1'b0) begin
            bad++;
            $display("FAIL d_write_resp got dresp=%b iresp=%b wr=%b exp 1 0 0", D_pmem_resp, I_pmem_resp, pmem_write);
        end
        tick();
        total++;
        if (D_pmem_resp !== 1'b0) begin
            bad++;
            $display("FAIL d_write_pulse got=%b exp=0", D_pmem_resp);
        end
    endtask

    task automatic test_tie();
        do_reset();
        I_pmem_read    = 1'b1;
        I_pmem_address = 16'h1111;
        D_pmem_read    = 1'b1;
        D_pmem_address = 16'h2222;
        tick();
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h2222) begin
            bad++;
            $display("FAIL tie_first got rd=%b addr=%h exp rd=1 addr=2222", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        total++;
        if (D_pmem_resp !== 1'b1 || I_pmem_resp !== 1'b0) begin
            bad++;
            $display("FAIL tie_first_resp got d=%b i=%b exp d=1 i=0", D_pmem_resp, I_pmem_resp);
        end
        tick();
        tick();
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h1111) begin
            bad++;
            $display("FAIL tie_second got rd=%b addr=%h exp rd=1 addr=1111", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        total++;
        if (I_pmem_resp !== 1'b1 || D_pmem_resp !== 1'b0) begin
            bad++;
            $display("FAIL tie_second_resp got i=%b d=%b exp i=1 d=0", I_pmem_resp, D_pmem_resp);
        end
        tick();
        tick();
        total++;
        if (pmem_address !== 16'h2222) begin
            bad++;
            $display("FAIL tie_third got addr=%h exp=2222", pmem_address);
        end
        clear_inputs();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_rw_both();
        do_reset();
        D_pmem_read    = 1'b1;
        D_pmem_write   = 1'b1;
        D_pmem_address = 16'h0ABC;
        D_pmem_wdata   = PAT_5A;
        tick();
        clear_inputs();
        total++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== PAT_5A) begin
            bad++;
            $display("FAIL rw_both got wr=%b rd=%b wdata=%h exp wr=1 rd=0", pmem_write, pmem_read, pmem_wdata);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int resp_seen;
        do_reset();
        D_pmem_write   = 1'b1;
        D_pmem_address = 16'h4000;
        D_pmem_wdata   = PAT_WD;
        tick();
        reset = 1'b0;
        clear_inputs();
        tick();
        reset = 1'b1;
        total++;
        if ({pmem_read, pmem_write, D_pmem_resp, I_pmem_resp} !== 4'b0 || pmem_address !== '0 || pmem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_mid got rd=%b wr=%b addr=%h wdata=%h exp all 0", pmem_read, pmem_write, pmem_address, pmem_wdata);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_A5;
        resp_seen  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (D_pmem_resp !== 1'b0 || I_pmem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0)
                resp_seen++;
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        total++;
        if (resp_seen !== 0) begin
            bad++;
            $display("FAIL reset_stale got=%0d active cycles exp=0", resp_seen);
        end
    endtask

    task automatic test_addr_change();
        do_reset();
        D_pmem_read    = 1'b1;
        D_pmem_address = 16'h4000;
        tick();
        D_pmem_address = 16'h5000;
        tick();
        total++;
        if (pmem_address !== 16'h4000 || pmem_read !== 1'b1) begin
            bad++;
            $display("FAIL addr_hold got addr=%h rd=%b exp addr=4000 rd=1", pmem_address, pmem_read);
        end
        D_pmem_read = 1'b0;
        pmem_resp   = 1'b1;
        pmem_rdata  = PAT_5A;
        tick();
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        total++;
        if (pmem_address !== 16'h4000 || D_pmem_resp !== 1'b1 || D_pmem_rdata !== PAT_5A) begin
            bad++;
            $display("FAIL addr_resp got addr=%h resp=%b rdata=%h exp addr=4000 resp=1 rdata=%h", pmem_address, D_pmem_resp, D_pmem_rdata, PAT_5A);
        end
        tick();
        total++;
        if (pmem_read !== 1'b0 || D_pmem_resp !== 1'b0) begin
            bad++;
            $display("FAIL addr_idle got rd=%b resp=%b exp 0 0", pmem_read, D_pmem_resp);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_tie();
        test_rw_both();
        test_reset_mid();
        test_addr_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 128, giving the cache line and pmem data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, giving the pmem address width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 SHALL have port I_pmem_read  input  1  read request from the instruction cache.
REQ-006 SHALL have port I_pmem_address  input  ADDR_WIDTH  line address from the instruction cache.
REQ-007 SHALL have port I_pmem_resp  output  1  completion pulse to the instruction cache.
REQ-008 SHALL have port I_pmem_rdata  output  LINE_WIDTH  returned line to the instruction cache.
REQ-009 SHALL have port D_pmem_read  input  1  read request from the data cache.
REQ-010 SHALL have port D_pmem_write  input  1  write-back request from the data cache.
REQ-011 SHALL have port D_pmem_address  input  ADDR_WIDTH  line address from the data cache.
REQ-012 SHALL have port D_pmem_wdata  input  LINE_WIDTH  write-back line from the data cache.
REQ-013 SHALL have port D_pmem_resp  output  1  completion pulse to the data cache.
REQ-014 SHALL have port D_pmem_rdata  output  LINE_WIDTH  returned line to the data cache.
REQ-015 SHALL have port pmem_read  output  1  read request to physical memory.
REQ-016 SHALL have port pmem_write  output  1  write request to physical memory.
REQ-017 SHALL have port pmem_address  output  ADDR_WIDTH  address to physical memory.
REQ-018 SHALL have port pmem_wdata  output  LINE_WIDTH  write line to physical memory.
REQ-019 SHALL have port pmem_resp  input  1  completion from physical memory.
REQ-020 SHALL have port pmem_rdata  input  LINE_WIDTH  read line from physical memory, valid with pmem_resp.

Function
REQ-021 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
REQ-022 IDLE: I request only -> SERVE_I; D request (read or write) only -> SERVE_D; none -> stay.
REQ-023 IDLE with I and D requests in the same cycle SHALL grant the side not granted last (1-bit last_grant register, reset value = I, so D wins first tie).
REQ-024 On grant SHALL latch address, direction (read/write) and, for D writes, wdata into internal registers; pmem_address/pmem_wdata SHALL be driven only from these registers.
REQ-025 D_pmem_read and D_pmem_write both high SHALL be treated as a write.
REQ-026 SERVE_x: pmem_read or pmem_write (per latched direction) SHALL be high from the first cycle after the grant edge until pmem_resp is sampled high; never both.
REQ-027 SERVE_x with pmem_resp=1 SHALL capture pmem_rdata into a LINE_WIDTH line buffer, update last_grant, move to RESP_x.
REQ-028 RESP_x SHALL last exactly one cycle: x_pmem_resp=1, pmem_read=pmem_write=0, then IDLE.
REQ-029 I_pmem_rdata and D_pmem_rdata SHALL both be driven from the line buffer; contents are meaningful only while the matching resp is high.
REQ-030 Latency: request high in IDLE cycle N -> pmem request high cycle N+1; pmem_resp cycle M -> x_pmem_resp high cycle M+1 only.
REQ-031 A requester dropping its request during SERVE_x SHALL NOT abort the transaction; it completes and RESP_x still pulses.
REQ-032 Request changes (address, wdata) during SERVE_x SHALL NOT affect pmem outputs.
REQ-033 pmem_resp high in IDLE or RESP_x SHALL be ignored.
REQ-034 The non-granted requester SHALL see resp=0 throughout and be served at the next IDLE evaluation.

Reset
REQ-035 reset=0 at a clk edge SHALL force IDLE, last_grant=I, all outputs and internal registers to 0, from any state including mid-transaction; the in-flight pmem transaction is abandoned.

Verification
REQ-036 I read addr 0x1230, pmem_resp after 3 cycles with rdata 0xA5..A5 -> pmem_read high 3 cycles at 0x1230, I_pmem_resp one cycle with 0xA5..A5, D_pmem_resp 0.
REQ-037 D write addr 0x4000 wdata 0x0123..EF -> pmem_write high, pmem_wdata 0x0123..EF, pmem_read 0, D_pmem_resp one cycle.
REQ-038 I and D requests same cycle after reset, held -> D served first, then I; reverse order on next tie.
REQ-039 D_pmem_read and D_pmem_write both high -> pmem_write only.
REQ-040 reset=0 during SERVE_D -> next cycle all outputs 0, IDLE; later pmem_resp ignored, no resp pulse.
REQ-041 D_pmem_address changed 0x4000->0x5000 mid-SERVE_D -> pmem_address stays 0x4000 until RESP_D.
